uart_tx_arbiter: RTL and testbench

Round-robin scheduler sharing the single UART transmitter among `NUM_REQ` byte sources, such as the command-response path and the echo path. Each source presents a byte with valid/ack. The arbiter picks one source, loads `tx_data`, and pulses `tx_start`. It then holds off further grants until the transmitter reports `tx_done`, so the transmitter never sees overlapping starts. A watchdog releases the resource if `tx_done` never arrives.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rr_pick.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   - arb_state_e     : arbiter FSM state encoding
//   - TIMEOUT_CYC_DEF : default watchdog limit in clock cycles
//   - cnt_width()     : width of the watchdog counter for a given limit
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_ARB       = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_e;

    localparam int TIMEOUT_CYC_DEF = 8192;

    // Enough bits to count 0 .. timeout_cyc-1. Never narrower than one bit,
    // so tiny limits still produce a legal vector.
    function automatic int cnt_width(input int timeout_cyc);
        return (timeout_cyc <= 2) ? 1 : $clog2(timeout_cyc);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// ----------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin picker. Searches the valid mask starting at
// ptr_i+1 and wrapping modulo NUM_REQ; the first set bit wins.
// Ports:
//   valid_i [NUM_REQ-1:0] : candidate requests
//   ptr_i   [IDX_W-1:0]   : index of the previous winner (lowest priority)
//   win_o   [IDX_W-1:0]   : winning index (0 when nothing is found)
//   found_o               : at least one candidate was valid
// ----------------------------------------------------------------------------
module uart_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   win_o,
    output logic               found_o
);

    always_comb begin
        logic hit;
        int   idx;
        hit   = 1'b0;
        idx   = 0;
        win_o = '0;
        // Offsets 1..NUM_REQ visit every index once, ending on ptr itself so a
        // lone requester can be granted back-to-back.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!hit && valid_i[IDX_W'(idx)]) begin
                hit   = 1'b1;
                win_o = IDX_W'(idx);
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// sources. A grant captures the winner's byte into tx_data, pulses tx_start
// and req_ack for one cycle, then holds off further grants until tx_done (or
// the watchdog gives up after TIMEOUT_CYC cycles in WAIT_DONE).
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   req_valid [NUM_REQ]    : requester i has a byte pending
//   req_data  [NUM_REQ*DATA_W] : byte of requester i at [i*DATA_W +: DATA_W]
//   req_last  [NUM_REQ]    : final byte of a packet (lock build only)
//   req_ack   [NUM_REQ]    : one-hot capture pulse
//   tx_data   [DATA_W]     : byte to the transmitter, held until next grant
//   tx_start               : one-cycle start pulse to the transmitter
//   tx_busy                : transmitter is shifting; blocks grants in ARB
//   tx_done                : transmitter finished a frame
//   grant_id               : index of the last granted requester
//   arb_busy               : high whenever the FSM is not in ARB
//   timeout_err            : one-cycle pulse when the watchdog aborts
//
// Build option: define UART_TX_ARB_LOCK_EN to keep arbitration on one
// requester from a req_last=0 grant until its req_last=1 grant (or timeout).
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy,
    input  logic                        tx_done,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        arb_busy,
    output logic                        timeout_err
);

    localparam int                IDX_W    = $clog2(NUM_REQ);
    localparam int                CNT_W    = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e          state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                tx_start_q;
    logic [NUM_REQ-1:0]  req_ack_q;
    logic [IDX_W-1:0]    grant_id_q;
    logic                arb_busy_q;
    logic                timeout_err_q;

    logic [NUM_REQ-1:0]  cand_mask_d;
    logic [IDX_W-1:0]    win_d;
    logic                found_d;
    logic [DATA_W-1:0]   win_data_d;
    logic [NUM_REQ-1:0]  win_onehot_d;
    logic                grant_d;
    logic                timeout_d;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_i (cand_mask_d),
        .ptr_i   (ptr_q),
        .win_o   (win_d),
        .found_o (found_d)
    );

    always_comb begin
        win_data_d   = '0;
        win_onehot_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_d == IDX_W'(i)) begin
                win_data_d      = req_data[i*DATA_W +: DATA_W];
                win_onehot_d[i] = 1'b1;
            end
        end
    end

    assign grant_d   = (state_q == ST_ARB) && found_d && !tx_busy;
    // tx_done takes precedence over the terminal count in the same cycle.
    assign timeout_d = (state_q == ST_WAIT_DONE) && !tx_done && (cnt_q == CNT_TERM);

`ifdef UART_TX_ARB_LOCK_EN
    logic                lock_q;
    logic [IDX_W-1:0]    lock_id_q;
    logic [NUM_REQ-1:0]  lock_mask_d;
    logic                win_last_d;

    always_comb begin
        lock_mask_d = '0;
        win_last_d  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (lock_id_q == IDX_W'(i)) lock_mask_d[i] = 1'b1;
            if (win_d == IDX_W'(i))     win_last_d     = req_last[i];
        end
        // While locked, other requesters are invisible to the picker.
        cand_mask_d = lock_q ? (req_valid & lock_mask_d) : req_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (grant_d) begin
            lock_q    <= !win_last_d;
            lock_id_q <= win_d;
        end else if (timeout_d) begin
            lock_q    <= 1'b0;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign cand_mask_d = req_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ARB;
            ptr_q         <= IDX_W'(NUM_REQ - 1);
            cnt_q         <= '0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            req_ack_q     <= '0;
            grant_id_q    <= '0;
            arb_busy_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            tx_start_q    <= 1'b0;
            req_ack_q     <= '0;
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_ARB: begin
                    if (grant_d) begin
                        tx_data_q  <= win_data_d;
                        tx_start_q <= 1'b1;
                        req_ack_q  <= win_onehot_d;
                        grant_id_q <= win_d;
                        ptr_q      <= win_d;
                        state_q    <= ST_SEND;
                        arb_busy_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    cnt_q      <= '0;
                    state_q    <= ST_WAIT_DONE;
                    arb_busy_q <= 1'b1;
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        state_q    <= ST_ARB;
                        arb_busy_q <= 1'b0;
                    end else if (timeout_d) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_ARB;
                        arb_busy_q    <= 1'b0;
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= ST_ARB;
                    arb_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign req_ack     = req_ack_q;
    assign grant_id    = grant_id_q;
    assign arb_busy    = arb_busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (NUM_REQ=2, DATA_W=8,
// TIMEOUT_CYC=16). Expected grants are queued as stimulus is driven and
// compared by a monitor whenever tx_start is seen.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ack;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_done;
    logic [0:0]  grant_id;
    logic        arb_busy;
    logic        timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        int         exp_id;
        logic [7:0] exp_data;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[8];

    int errors  = 0;
    int checks  = 0;
    int n_start = 0;
    int n_tmo   = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Returns at the falling edge of the cycle in which tx_start is high.
    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_start) begin
                ok = 1'b1;
                return;
            end
        end
        chk("start_seen", 32'(tx_start), 32'd1);
    endtask

    // Called at the falling edge of the start cycle S: drops the given
    // requests, returns tx_done during cycle S+gap, checks return to ARB.
    task automatic after_start(input logic [1:0] drop, input int gap);
        tick();
        req_valid = req_valid & ~drop;
        @(negedge clk);
        chk("start_one_cycle", 32'(tx_start), 32'd0);
        chk("busy_in_wait", 32'(arb_busy), 32'd1);
        repeat (gap - 1) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        @(negedge clk);
        chk("back_to_arb", 32'(arb_busy), 32'd0);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_start"},    32'(tx_start),    32'd0);
        chk({tag, "_req_ack"},     32'(req_ack),     32'd0);
        chk({tag, "_grant_id"},    32'(grant_id),    32'd0);
        chk({tag, "_arb_busy"},    32'(arb_busy),    32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_tx_data"},     32'(tx_data),     32'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (timeout_err) n_tmo++;
        chk("ack_with_start", 32'(req_ack != 2'b00), 32'(tx_start));
        if (tx_start) begin
            n_start++;
            chk("start_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("tx_data",  32'(tx_data),  32'(mon_e.data));
                chk("grant_id", 32'(grant_id), 32'(mon_e.id));
                chk("req_ack",  32'(req_ack),  32'd1 << mon_e.id);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit ok;
        int s;
        int prev;
        int tmo0;
        int t_at;
        int idx0;
        logic acked0;

        // Round-robin table; ptr is 0 when it starts (after the busy test).
        vecs[0] = '{2'b01, 8'h55, 8'h00, 0, 8'h55};
        vecs[1] = '{2'b11, 8'h11, 8'h22, 1, 8'h22};
        vecs[2] = '{2'b11, 8'h33, 8'h44, 0, 8'h33};
        vecs[3] = '{2'b10, 8'h00, 8'h66, 1, 8'h66};
        vecs[4] = '{2'b10, 8'h00, 8'h77, 1, 8'h77};
        vecs[5] = '{2'b01, 8'h88, 8'h00, 0, 8'h88};
        vecs[6] = '{2'b11, 8'hFF, 8'h00, 1, 8'h00};
        vecs[7] = '{2'b01, 8'hC3, 8'h00, 0, 8'hC3};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b1;
        tx_done   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");

        // Busy hold-off: no grant while tx_busy, grant the cycle after it falls.
        tick();
        push_exp(0, 8'h5A);
        req_valid = 2'b01;
        req_data  = 16'h005A;
        repeat (6) tick();
        chk("busy_hold_starts", 32'(n_start), 32'd0);
        tx_busy = 1'b0;
        @(negedge clk);
        chk("busy_fall_no_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        chk("busy_grant_next", 32'(tx_start), 32'd1);
        after_start(2'b01, 3);

        // Table-driven single transactions.
        for (int v = 0; v < 8; v++) begin
            tick();
            push_exp(vecs[v].exp_id, vecs[v].exp_data);
            req_valid = vecs[v].valid;
            req_data  = {vecs[v].d1, vecs[v].d0};
            wait_start(ok);
            if (ok) after_start(2'b11, 3);
        end

        // Contention: both valid continuously, tx_done 10 cycles after start.
        do_reset();
        push_exp(0, 8'hA1);
        push_exp(1, 8'hB2);
        push_exp(0, 8'hA1);
        push_exp(1, 8'hB2);
        s    = n_start;
        prev = 0;
        req_valid = 2'b11;
        req_data  = {8'hB2, 8'hA1};
        for (int k = 0; k < 4; k++) begin
            wait_start(ok);
            if (!ok) break;
            if (k > 0) chk("regrant_spacing", 32'(cyc - prev), 32'd12);
            prev = cyc;
            tick();
            if (k == 3) req_valid = 2'b00;
            repeat (9) tick();
            chk("one_start_per_frame", 32'(n_start - s), 32'(k + 1));
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        @(negedge clk);
        chk("contention_idle", 32'(arb_busy), 32'd0);

        // Watchdog: tx_done never returned.
        tick();
        push_exp(0, 8'hC0);
        req_valid = 2'b01;
        req_data  = 16'h00C0;
        wait_start(ok);
        s    = cyc;
        tmo0 = n_tmo;
        t_at = -1;
        tick();
        req_valid = 2'b00;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (timeout_err && t_at < 0) begin
                t_at = cyc;
                chk("timeout_arb_busy", 32'(arb_busy), 32'd0);
            end
        end
        chk("timeout_offset", 32'(t_at - s), 32'd17);
        chk("timeout_pulse_count", 32'(n_tmo - tmo0), 32'd1);
        tick();
        push_exp(1, 8'hE1);
        req_valid = 2'b11;
        req_data  = {8'hE1, 8'hE0};
        wait_start(ok);
        if (ok) after_start(2'b11, 3);

        // tx_done coinciding with the terminal count: no error pulse.
        tick();
        push_exp(0, 8'hD5);
        req_valid = 2'b01;
        req_data  = 16'h00D5;
        wait_start(ok);
        tmo0 = n_tmo;
        tick();
        req_valid = 2'b00;
        repeat (15) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        @(negedge clk);
        chk("done_wins_arb", 32'(arb_busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("done_wins_no_err", 32'(n_tmo - tmo0), 32'd0);

        // Packet lock: req0 sends 3 bytes while req1 stays valid.
        do_reset();
`ifdef UART_TX_ARB_LOCK_EN
        push_exp(0, 8'h01);
        push_exp(0, 8'h02);
        push_exp(0, 8'h03);
        push_exp(1, 8'h99);
`else
        push_exp(0, 8'h01);
        push_exp(1, 8'h99);
        push_exp(0, 8'h02);
        push_exp(1, 8'h99);
`endif
        idx0      = 0;
        req_valid = 2'b11;
        req_data  = {8'h99, 8'h01};
        req_last  = 2'b00;
        for (int g = 0; g < 4; g++) begin
            wait_start(ok);
            if (!ok) break;
            acked0 = req_ack[0];
            tick();
            if (acked0) begin
                idx0++;
                if (idx0 == 3) begin
                    req_valid[0] = 1'b0;
                end else begin
                    req_data[7:0] = 8'(idx0 + 1);
                    req_last[0]   = (idx0 == 2);
                end
            end
            if (g == 3) req_valid = 2'b00;
            repeat (2) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        req_last = 2'b00;
        @(negedge clk);
        chk("lock_idle", 32'(arb_busy), 32'd0);

        // Reset while in WAIT_DONE: ack pending state lost, req0 first after.
        tick();
        push_exp(0, 8'h5C);
        req_valid = 2'b01;
        req_data  = 16'h005C;
        wait_start(ok);
        tick();
        req_valid = 2'b11;
        req_data  = {8'h6D, 8'h7E};
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        push_exp(0, 8'h7E);
        wait_start(ok);
        if (ok) after_start(2'b11, 3);

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
